button_conditioner: RTL and testbench

//  Upstream input stage for the VGA game top level. Conditions the raw active-low

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 13 +
 rtl/button_conditioner_btn_debounce_ch.sv | 115 +++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button input stage: per-channel debounce
// states and the bit position of each button in the key/level vectors.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button pins and the conditioned level/strobe outputs.
// The slave side is the conditioner; the master side drives the pins.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] key_n;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (output key_n, input btn_level, btn_press, btn_release);
  modport slave  (input key_n, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_conditioner_btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, inversion, debounce FSM with a
// stability counter, and registered level/press/release outputs.
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q, sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             s;

  // Synchroniser idles at 1 so reset looks like a released button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the game top level: NUM_BTN independent debounced channels
// (0=start 1=up 2=left 3=right) producing level, press and release.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  btn
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .key_n_i   (btn.key_n[gi]),
      .level_o   (level_w[gi]),
      .press_o   (press_w[gi]),
      .release_o (release_w[gi])
    );
  end

  assign btn.btn_level   = level_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window (4 cycles);
// edge indices count from the first rising edge that samples the new key value.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int NB = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  button_conditioner_if #(.NUM_BTN(NB)) bus ();

  button_conditioner #(
    .NUM_BTN      (NB),
    .DEBOUNCE_CNT (4),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.key_n = '1;
    tick();
    tick();
    tests_run++;
    if (bus.btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_level got %b want 0000", bus.btn_level);
    end
    tests_run++;
    if ({bus.btn_press, bus.btn_release} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_strobes got %b want 00000000", {bus.btn_press, bus.btn_release});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_clean_press();
    int first_rise = -1, press_cnt = 0, press_edge = -1, rel_cnt = 0, rel_edge = -1;
    logic [NB-1:0] others = '0;
    bus.key_n[BTN_START] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.btn_level[0] && first_rise < 0) first_rise = i;
      if (bus.btn_press[0]) begin press_cnt++; press_edge = i; end
      others |= {bus.btn_level[3:1], 1'b0} | {bus.btn_press[3:1], 1'b0} | bus.btn_release;
    end
    tests_run++;
    if (first_rise !== 7) begin
      tests_failed++;
      $display("FAIL press_level_latency got edge %0d want 7", first_rise);
    end
    tests_run++;
    if (press_cnt !== 1 || press_edge !== 7) begin
      tests_failed++;
      $display("FAIL press_strobe got count %0d edge %0d want 1 at 7", press_cnt, press_edge);
    end
    tests_run++;
    if (others !== 4'b0000) begin
      tests_failed++;
      $display("FAIL press_other_bits got %b want 0000", others);
    end
    bus.key_n[BTN_START] = 1'b1;
    first_rise = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!bus.btn_level[0] && first_rise < 0) first_rise = i;
      if (bus.btn_release[0]) begin rel_cnt++; rel_edge = i; end
    end
    tests_run++;
    if (rel_cnt !== 1 || rel_edge !== 7 || first_rise !== 7) begin
      tests_failed++;
      $display("FAIL release_strobe got count %0d edge %0d fall %0d want 1 at 7 fall 7",
               rel_cnt, rel_edge, first_rise);
    end
  endtask

  task automatic test_glitch();
    logic [NB-1:0] seen = '0;
    bus.key_n[BTN_RIGHT] = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 3) bus.key_n[BTN_RIGHT] = 1'b1;
      seen |= bus.btn_level | bus.btn_press | bus.btn_release;
    end
    tests_run++;
    if (seen !== 4'b0000) begin
      tests_failed++;
      $display("FAIL glitch_outputs got %b want 0000", seen);
    end
  endtask

  task automatic test_release_bounce();
    int rel_cnt = 0, rel_edge = -1;
    logic lvl_dropped = 1'b0;
    bus.key_n[BTN_UP] = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    tests_run++;
    if (bus.btn_level[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce_setup_level got %b want 1", bus.btn_level[1]);
    end
    bus.key_n[BTN_UP] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 2) bus.key_n[BTN_UP] = 1'b0;
      if (!bus.btn_level[1]) lvl_dropped = 1'b1;
      if (bus.btn_release[1]) rel_cnt++;
    end
    tests_run++;
    if (lvl_dropped !== 1'b0 || rel_cnt !== 0) begin
      tests_failed++;
      $display("FAIL bounce_held got dropped %b releases %0d want 0 and 0", lvl_dropped, rel_cnt);
    end
    bus.key_n[BTN_UP] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.btn_release[1]) begin rel_cnt++; rel_edge = i; end
    end
    tests_run++;
    if (rel_cnt !== 1 || rel_edge !== 7 || bus.btn_level[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_final_release got count %0d edge %0d level %b want 1 at 7 level 0",
               rel_cnt, rel_edge, bus.btn_level[1]);
    end
  endtask

  task automatic test_simultaneous();
    int e1 = -1, e2 = -1, c1 = 0, c2 = 0;
    bus.key_n[BTN_UP]   = 1'b0;
    bus.key_n[BTN_LEFT] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (bus.btn_press[1]) begin c1++; e1 = i; end
      if (bus.btn_press[2]) begin c2++; e2 = i; end
    end
    tests_run++;
    if (c1 !== 1 || c2 !== 1 || e1 !== 7 || e2 !== 7) begin
      tests_failed++;
      $display("FAIL simultaneous_press got ch1 %0d@%0d ch2 %0d@%0d want 1@7 1@7", c1, e1, c2, e2);
    end
    bus.key_n = '1;
    for (int i = 1; i <= 12; i++) tick();
    tests_run++;
    if (bus.btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL simultaneous_release_level got %b want 0000", bus.btn_level);
    end
  endtask

  task automatic test_reset_mid_wait();
    int c = 0, e = -1;
    bus.key_n[BTN_START] = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_async_outputs got %h want 000", {bus.btn_level, bus.btn_press, bus.btn_release});
    end
    tick();
    tick();
    tests_run++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold_outputs got %h want 000", {bus.btn_level, bus.btn_press, bus.btn_release});
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.btn_press[0]) begin c++; e = i; end
    end
    tests_run++;
    if (c !== 1 || e !== 7) begin
      tests_failed++;
      $display("FAIL reset_fresh_press got count %0d edge %0d want 1 at 7", c, e);
    end
    bus.key_n = '1;
    for (int i = 1; i <= 12; i++) tick();
  endtask

  task automatic test_long_hold();
    int presses = 0, releases = 0, level_changes = 0, back_to_back = 0;
    logic prev_lvl = 1'b0, prev_press = 1'b0;
    bus.key_n[BTN_START] = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (bus.btn_press[0]) presses++;
      if (bus.btn_release[0]) releases++;
      if (bus.btn_level[0] !== prev_lvl) level_changes++;
      if (bus.btn_press[0] && prev_press) back_to_back++;
      prev_lvl   = bus.btn_level[0];
      prev_press = bus.btn_press[0];
    end
    tests_run++;
    if (presses !== 1 || releases !== 0) begin
      tests_failed++;
      $display("FAIL long_hold_strobes got press %0d release %0d want 1 and 0", presses, releases);
    end
    tests_run++;
    if (level_changes !== 1 || bus.btn_level[0] !== 1'b1 || back_to_back !== 0) begin
      tests_failed++;
      $display("FAIL long_hold_level got changes %0d level %b b2b %0d want 1 1 0",
               level_changes, bus.btn_level[0], back_to_back);
    end
    bus.key_n = '1;
    for (int i = 1; i <= 12; i++) tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.key_n    = '1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_wait();
    test_long_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
